gelato_ram_arbiter: RTL and testbench

- Shares the single GPU memory port between REQ_NUM requesters, e.g. instruction fetch, LSU and init loader.
- Sits between the gelato core's memory clients and the RAM model or controller.
- Round-robin grant with one outstanding transaction at a time.
- Routes each RAM response back to the requester that issued it.

---
 rtl/gelato_ram_arbiter.sv | 139 +++++++++++++
 tb/tb_gelato_ram_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gelato_ram_arbiter.sv
// Round-robin arbiter sharing one RAM port among REQ_NUM requesters.
// One transaction in flight; each response is routed back to the requester that issued it.
module gelato_ram_arbiter #(
  parameter int REQ_NUM    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rdy,
  input  logic [REQ_NUM-1:0]            req_valid,
  output logic [REQ_NUM-1:0]            req_ready,
  input  logic [REQ_NUM-1:0]            req_wr,
  input  logic [REQ_NUM*ADDR_WIDTH-1:0] req_addr,
  input  logic [REQ_NUM*DATA_WIDTH-1:0] req_wdata,
  output logic [REQ_NUM-1:0]            resp_valid,
  output logic [DATA_WIDTH-1:0]         resp_rdata,
  output logic                          ram_valid,
  input  logic                          ram_ready,
  output logic                          ram_wr,
  output logic [ADDR_WIDTH-1:0]         ram_addr,
  output logic [DATA_WIDTH-1:0]         ram_wdata,
  input  logic                          ram_resp_valid,
  input  logic [DATA_WIDTH-1:0]         ram_rdata
);

  localparam int PtrW = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e                state_q, state_d;
  logic [PtrW-1:0]       rr_q, rr_d;
  logic [PtrW-1:0]       owner_q, owner_d;
  logic [PtrW-1:0]       win_idx, win_next;
  logic [PtrW:0]         cand;
  logic                  win_found, grant;
  logic                  sel_wr;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  ram_wr_d;
  logic [ADDR_WIDTH-1:0] ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_wdata_d;
  logic [REQ_NUM-1:0]    resp_valid_d;
  logic [DATA_WIDTH-1:0] resp_rdata_d;

  // First valid requester at or after the pointer, wrapping past REQ_NUM-1.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      cand = {1'b0, rr_q} + (PtrW+1)'(i);
      if (cand >= (PtrW+1)'(REQ_NUM)) cand = cand - (PtrW+1)'(REQ_NUM);
      if (!win_found && req_valid[cand[PtrW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[PtrW-1:0];
      end
    end
  end

  assign win_next  = (win_idx == PtrW'(REQ_NUM - 1)) ? '0 : win_idx + PtrW'(1);
  // rst_n gates the handshake so nothing is offered while reset is held.
  assign grant     = rst_n && rdy && (state_q == StIdle) && win_found;
  assign ram_valid = (state_q == StIssue);

  always_comb begin
    req_ready = '0;
    sel_wr    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      req_ready[i] = grant && (win_idx == PtrW'(i));
      if (win_idx == PtrW'(i)) begin
        sel_wr    = req_wr[i];
        sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    owner_d      = owner_q;
    ram_wr_d     = ram_wr;
    ram_addr_d   = ram_addr;
    ram_wdata_d  = ram_wdata;
    resp_valid_d = rdy ? '0 : resp_valid;
    resp_rdata_d = resp_rdata;
    if (rdy) begin
      case (state_q)
        StIdle: begin
          if (grant) begin
            ram_wr_d    = sel_wr;
            ram_addr_d  = sel_addr;
            ram_wdata_d = sel_wdata;
            owner_d     = win_idx;
            rr_d        = win_next;
            state_d     = StIssue;
          end
        end
        StIssue: begin
          if (ram_ready) state_d = StWait;
        end
        StWait: begin
          if (ram_resp_valid) begin
            resp_rdata_d = ram_rdata;
            for (int i = 0; i < REQ_NUM; i++) resp_valid_d[i] = (owner_q == PtrW'(i));
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      rr_q       <= '0;
      owner_q    <= '0;
      ram_wr     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      resp_valid <= '0;
      resp_rdata <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      owner_q    <= owner_d;
      ram_wr     <= ram_wr_d;
      ram_addr   <= ram_addr_d;
      ram_wdata  <= ram_wdata_d;
      resp_valid <= resp_valid_d;
      resp_rdata <= resp_rdata_d;
    end
  end

endmodule

// File: tb/tb_gelato_ram_arbiter.sv
// Directed bench for gelato_ram_arbiter: 2-requester instance for most cases,
// 3-requester instance for pointer wrap; scoreboard queues checked by a monitor.
module tb_gelato_ram_arbiter;

  logic clk = 1'b0;
  logic rst_n, rdy;
  always #5 clk = ~clk;

  logic [1:0]  req_valid, req_ready, req_wr, resp_valid;
  logic [63:0] req_addr, req_wdata;
  logic [31:0] resp_rdata, ram_addr, ram_wdata, ram_rdata;
  logic        ram_valid, ram_ready, ram_wr, ram_resp_valid;

  logic [2:0]  req3_valid, req3_ready, req3_wr, resp3_valid;
  logic [95:0] req3_addr, req3_wdata;
  logic [31:0] resp3_rdata, ram3_addr, ram3_wdata, ram3_rdata;
  logic        ram3_valid, ram3_ready, ram3_wr, ram3_resp_valid;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    int          who;
  } txn_t;

  txn_t iss_q[$], rsp_q[$], iss3_q[$], rsp3_q[$];
  int   issued[3], done[3], issued3[3], done3[3];
  int   n_checks = 0, n_errors = 0, pulses = 0;
  int   ready_delay, resp_delay, issue_cnt, wait_cnt;
  logic in_wait, prev_v, prev_v3, model_ready, model_resp, force_resp, resp3;
  logic prev_rdy, prev_rresp;
  logic [2:0] acc, acc3;

  function automatic logic [31:0] ram_data(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : {a[15:0], ~a[15:0]};
  endfunction

  always_comb begin
    req_valid  = '0;
    req3_valid = '0;
    for (int i = 0; i < 2; i++) req_valid[i] = (issued[i] != done[i]);
    for (int i = 0; i < 3; i++) req3_valid[i] = (issued3[i] != done3[i]);
  end

  assign ram_ready       = model_ready;
  assign ram_resp_valid  = model_resp | force_resp;
  assign ram_rdata       = ram_data(ram_addr);
  assign ram3_ready      = 1'b1;
  assign ram3_resp_valid = resp3;
  assign ram3_rdata      = ram_data(ram3_addr);

  gelato_ram_arbiter #(.REQ_NUM(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .ram_valid(ram_valid), .ram_ready(ram_ready), .ram_wr(ram_wr),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_resp_valid(ram_resp_valid), .ram_rdata(ram_rdata)
  );

  gelato_ram_arbiter #(.REQ_NUM(3), .ADDR_WIDTH(32), .DATA_WIDTH(32)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .rdy(rdy),
    .req_valid(req3_valid), .req_ready(req3_ready), .req_wr(req3_wr),
    .req_addr(req3_addr), .req_wdata(req3_wdata),
    .resp_valid(resp3_valid), .resp_rdata(resp3_rdata),
    .ram_valid(ram3_valid), .ram_ready(ram3_ready), .ram_wr(ram3_wr),
    .ram_addr(ram3_addr), .ram_wdata(ram3_wdata),
    .ram_resp_valid(ram3_resp_valid), .ram_rdata(ram3_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // RAM model: ready after ready_delay ISSUE cycles, responds resp_delay cycles into WAIT.
  initial begin
    model_ready = 0; model_resp = 0; in_wait = 0; prev_v = 0; prev_v3 = 0; resp3 = 0;
    issue_cnt = 0; wait_cnt = 0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        model_ready = 0; model_resp = 0; in_wait = 0; prev_v = 0; prev_v3 = 0; resp3 = 0;
        issue_cnt = 0; wait_cnt = 0;
      end else begin
        if (ram_valid) begin
          issue_cnt++;
          model_ready = (issue_cnt > ready_delay);
        end else begin
          issue_cnt = 0;
          model_ready = 0;
        end
        if (in_wait && resp_valid != 2'b00) in_wait = 0;
        if (prev_v && !ram_valid) begin
          in_wait = 1;
          wait_cnt = 0;
        end
        if (in_wait) begin
          wait_cnt++;
          model_resp = (wait_cnt >= resp_delay);
        end else begin
          model_resp = 0;
        end
        prev_v  = ram_valid;
        resp3   = prev_v3 && !ram3_valid;
        prev_v3 = ram3_valid;
      end
    end
  end

  // Requesters: drop a pending request once its handshake completes; reset abandons all.
  initial begin
    forever begin
      @(negedge clk);
      acc  = {1'b0, req_valid & req_ready};
      acc3 = req3_valid & req3_ready;
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
        if (!rst_n) begin
          done[i]  = issued[i];
          done3[i] = issued3[i];
        end else begin
          if (acc[i])  done[i]++;
          if (acc3[i]) done3[i]++;
        end
      end
    end
  end

  // Monitor: compares RAM-side requests and responses against the expected queues.
  initial begin
    txn_t t;
    prev_rdy = 0; prev_rresp = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_rdy = 0; prev_rresp = 0;
      end else begin
        chk("req_ready_onehot0", 64'($onehot0(req_ready)), 1);
        chk("resp_valid_onehot0", 64'($onehot0(resp_valid)), 1);
        if (ram_valid) begin
          chk("issue_expected", 64'(iss_q.size() != 0), 1);
          if (iss_q.size() != 0) begin
            chk("ram_addr", ram_addr, iss_q[0].addr);
            chk("ram_wr", ram_wr, iss_q[0].wr);
            if (iss_q[0].wr) chk("ram_wdata", ram_wdata, iss_q[0].wdata);
            if (ram_ready && rdy) void'(iss_q.pop_front());
          end
        end
        if (resp_valid != 2'b00 && prev_rdy) begin
          pulses++;
          chk("resp_after_ram_resp", 64'(prev_rresp), 1);
          chk("resp_expected", 64'(rsp_q.size() != 0), 1);
          if (rsp_q.size() != 0) begin
            t = rsp_q.pop_front();
            chk("resp_valid", resp_valid, 64'(1) << t.who);
            if (!t.wr) chk("resp_rdata", resp_rdata, ram_data(t.addr));
          end
        end
        if (ram3_valid && rdy) begin
          chk("issue3_expected", 64'(iss3_q.size() != 0), 1);
          if (iss3_q.size() != 0) begin
            t = iss3_q.pop_front();
            chk("ram3_addr", ram3_addr, t.addr);
          end
        end
        if (resp3_valid != 3'b000 && prev_rdy) begin
          chk("resp3_expected", 64'(rsp3_q.size() != 0), 1);
          if (rsp3_q.size() != 0) begin
            t = rsp3_q.pop_front();
            chk("resp3_valid", resp3_valid, 64'(1) << t.who);
            chk("resp3_rdata", resp3_rdata, ram_data(t.addr));
          end
        end
        prev_rdy   = rdy;
        prev_rresp = ram_resp_valid;
      end
    end
  end

  task automatic issue(input int who, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata);
    txn_t t;
    req_wr[who] = wr;
    req_addr[who*32 +: 32]  = addr;
    req_wdata[who*32 +: 32] = wdata;
    issued[who]++;
    t.addr = addr; t.wr = wr; t.wdata = wdata; t.who = who;
    iss_q.push_back(t);
    rsp_q.push_back(t);
  endtask

  task automatic issue3(input int who, input logic [31:0] addr);
    txn_t t;
    req3_addr[who*32 +: 32] = addr;
    issued3[who]++;
    t.addr = addr; t.wr = 1'b0; t.wdata = '0; t.who = who;
    iss3_q.push_back(t);
    rsp3_q.push_back(t);
  endtask

  task automatic wait_drain(input int limit);
    bit empty;
    empty = 0;
    for (int k = 0; k < limit && !empty; k++) begin
      @(negedge clk);
      empty = (iss_q.size() == 0) && (rsp_q.size() == 0) &&
              (iss3_q.size() == 0) && (rsp3_q.size() == 0);
    end
    chk("drain", 64'(empty), 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_in_wait();
    bit seen, reached;
    seen = 0; reached = 0;
    for (int k = 0; k < 40 && !reached; k++) begin
      @(negedge clk);
      if (ram_valid) seen = 1;
      else if (seen) reached = 1;
    end
    chk("reached_wait", 64'(reached), 1);
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  initial begin
    int p0, cnt;
    rst_n = 0; rdy = 1; force_resp = 0; ready_delay = 0; resp_delay = 1;
    req_wr = '0; req_addr = '0; req_wdata = '0;
    req3_wr = '0; req3_addr = '0; req3_wdata = '0;
    #12;
    chk("rst_ram_valid", 64'(ram_valid), 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;

    // Single read with minimum latency.
    issue(0, 1'b0, 32'h100, 32'h0);
    @(negedge clk); chk("t1_c0_req_ready", req_ready, 2'b01);
    chk("t1_c0_ram_valid", 64'(ram_valid), 0);
    @(negedge clk); chk("t1_c1_ram_valid", 64'(ram_valid), 1);
    chk("t1_c1_ram_addr", ram_addr, 32'h100);
    @(negedge clk); chk("t1_c2_resp_valid", resp_valid, 2'b00);
    @(negedge clk); chk("t1_c3_resp_valid", resp_valid, 2'b01);
    chk("t1_c3_resp_rdata", resp_rdata, 32'hDEADBEEF);
    wait_drain(20);

    // Contention: both requesters continuously valid, pointer starts at 0.
    do_reset();
    issue(0, 1'b0, 32'h10, 32'h0);
    issue(1, 1'b0, 32'h20, 32'h0);
    issue(0, 1'b0, 32'h10, 32'h0);
    issue(1, 1'b0, 32'h20, 32'h0);
    wait_drain(60);

    // Write ack with ram_ready delayed 3 cycles.
    do_reset();
    ready_delay = 3;
    issue(1, 1'b1, 32'h40, 32'hCAFE0001);
    p0 = pulses; cnt = 0;
    for (int k = 0; k < 30 && pulses == p0; k++) begin
      @(negedge clk);
      if (ram_valid) cnt++;
    end
    chk("t3_write_resp_seen", 64'(pulses != p0), 1);
    chk("t3_ram_valid_cycles", 64'(cnt), 4);
    ready_delay = 0;
    wait_drain(20);

    // rdy stall: in IDLE no handshake, in WAIT everything frozen.
    do_reset();
    rdy = 0; resp_delay = 10;
    issue(0, 1'b0, 32'h80, 32'h0);
    repeat (2) begin
      @(negedge clk); chk("t4_idle_stall_ready", req_ready, 2'b00);
    end
    @(posedge clk); #1; rdy = 1;
    wait_in_wait();
    @(posedge clk); #1; rdy = 0;
    p0 = pulses;
    repeat (5) begin
      @(negedge clk);
      chk("t4_stall_ram_valid", 64'(ram_valid), 0);
      chk("t4_stall_resp_valid", resp_valid, 2'b00);
      chk("t4_stall_ram_resp", 64'(ram_resp_valid), 0);
    end
    @(posedge clk); #1; rdy = 1;
    wait_drain(40);
    repeat (4) @(negedge clk);
    chk("t4_single_pulse", 64'(pulses - p0), 1);

    // Reset in WAIT abandons the transaction; stale RAM response is ignored.
    issue(0, 1'b1, 32'h200, 32'h12345678);
    wait_in_wait();
    @(posedge clk); #2; rst_n = 0;
    #1;
    chk("t5_ram_valid", 64'(ram_valid), 0);
    chk("t5_ram_wr", 64'(ram_wr), 0);
    chk("t5_ram_addr", ram_addr, 0);
    chk("t5_ram_wdata", ram_wdata, 0);
    chk("t5_resp_valid", resp_valid, 0);
    chk("t5_resp_rdata", resp_rdata, 0);
    chk("t5_req_ready", req_ready, 0);
    iss_q.delete(); rsp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1; resp_delay = 1;
    @(posedge clk); #1; force_resp = 1;
    repeat (2) begin
      @(negedge clk);
      chk("t5_stale_resp_valid", resp_valid, 2'b00);
      chk("t5_stale_ram_valid", 64'(ram_valid), 0);
    end
    @(posedge clk); #1; force_resp = 0;
    issue(1, 1'b0, 32'h240, 32'h0);
    @(negedge clk); chk("t5_req1_wins", req_ready, 2'b10);
    wait_drain(20);

    // Pointer wrap on the 3-requester instance.
    do_reset();
    issue3(0, 32'h300);
    wait_drain(20);
    issue3(2, 32'h320);
    issue3(0, 32'h300);
    issue3(2, 32'h320);
    @(negedge clk); chk("t6_first_grant", req3_ready, 3'b100);
    wait_drain(60);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
